// File: rtl/home_auto_pkg.sv
// Shared types and helpers for the home automation round-robin scheduler.
// Holds the scheduler state enum, display codes and slot/width helpers.
package home_auto_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_e;

    localparam int DISP_NONE   = 0;
    localparam int DISP_CH_OFS = 1;

    // The temperature slot sits right after the last sensor channel.
    function automatic int ts_slot(input int n_sens);
        return n_sens;
    endfunction

    // Display codes run 0 .. n_sens+1.
    function automatic int disp_width(input int n_sens);
        return $clog2(n_sens + 2);
    endfunction

endpackage

// File: rtl/ha_hold_timer.sv
// Loadable down-counter timing how long a granted actuator stays on.
// Ports: clk, rst (async, active-high), load (reload to HOLD_CYC-1),
// abort (clear to zero; load wins), done (count is zero).
module ha_hold_timer #(
    parameter int  HOLD_CYC = 3,
    localparam int CW       = $clog2(HOLD_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic abort,
    output logic done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign done = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(HOLD_CYC - 1);
        end else if (abort) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/home_auto_rr_scheduler.sv
// Round-robin service scheduler for N_SENS sensor channels plus one
// temperature slot, with a rising-edge pre-emptive urgent channel.
// Ports: clk, Rst (async, active-high), sens (request levels),
// temp (unsigned sample); registered outputs act (one-hot),
// cooler, heater, display (0 none, k+1 channel k, N_SENS+1 temp),
// busy (high while an actuator is being held).
module home_auto_rr_scheduler
    import home_auto_pkg::*;
#(
    parameter int  N_SENS   = 4,
    parameter int  TEMP_W   = 8,
    parameter int  T_LOW    = 50,
    parameter int  T_HIGH   = 70,
    parameter int  HOLD_CYC = 3,
    parameter int  URG_IDX  = 2,
    localparam int DW       = disp_width(N_SENS)
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [N_SENS-1:0] sens,
    input  logic [TEMP_W-1:0] temp,
    output logic [N_SENS-1:0] act,
    output logic              cooler,
    output logic              heater,
    output logic [DW-1:0]     display,
    output logic              busy
);

    localparam int TS = ts_slot(N_SENS);
    localparam int PW = $clog2(N_SENS + 1);

    localparam logic [TEMP_W-1:0] T_LO = TEMP_W'(T_LOW);
    localparam logic [TEMP_W-1:0] T_HI = TEMP_W'(T_HIGH);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              urg_prev_q, urg_prev_d;
    logic [N_SENS-1:0] act_q, act_d;
    logic              cooler_q, cooler_d;
    logic              heater_q, heater_d;
    logic [DW-1:0]     display_q, display_d;
    logic              busy_q, busy_d;

    logic              temp_req;
    logic [N_SENS:0]   req;
    logic              any_req;
    logic              urg_rise;
    logic              at_ts;
    logic [PW-1:0]     ptr_nxt;
    logic              tmr_load;
    logic              tmr_abort;
    logic              tmr_done;

    assign temp_req = (temp < T_LO) || (temp > T_HI);
    assign req      = {temp_req, sens};
    assign any_req  = |req;
    assign urg_rise = sens[URG_IDX] & ~urg_prev_q;
    assign at_ts    = (ptr_q == PW'(TS));
    assign ptr_nxt  = at_ts ? '0 : ptr_q + 1'b1;

    // Keep the timer parked at zero whenever nothing is being held.
    assign tmr_abort = (state_q != HOLD);

    ha_hold_timer #(
        .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (Rst),
        .load  (tmr_load),
        .abort (tmr_abort),
        .done  (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        urg_prev_d = sens[URG_IDX];
        act_d      = '0;
        cooler_d   = 1'b0;
        heater_d   = 1'b0;
        display_d  = DW'(DISP_NONE);
        busy_d     = 1'b0;
        tmr_load   = 1'b0;

        if (urg_rise) begin
            // Pre-emption leaves ptr alone so the scan resumes in place.
            state_d   = HOLD;
            act_d     = N_SENS'(1) << URG_IDX;
            display_d = DW'(URG_IDX + DISP_CH_OFS);
            busy_d    = 1'b1;
            tmr_load  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (req[ptr_q]) begin
                        state_d   = HOLD;
                        ptr_d     = ptr_nxt;
                        act_d     = at_ts ? '0
                                          : N_SENS'(1) << ptr_q;
                        cooler_d  = at_ts && (temp > T_HI);
                        heater_d  = at_ts && (temp < T_LO);
                        display_d = DW'(ptr_q) + DW'(DISP_CH_OFS);
                        busy_d    = 1'b1;
                        tmr_load  = 1'b1;
                    end else if (!any_req) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_nxt;
                    end
                end
                HOLD: begin
                    if (tmr_done) begin
                        state_d = SCAN;
                    end else begin
                        act_d     = act_q;
                        cooler_d  = cooler_q;
                        heater_d  = heater_q;
                        display_d = display_q;
                        busy_d    = busy_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            urg_prev_q <= 1'b0;
            act_q      <= '0;
            cooler_q   <= 1'b0;
            heater_q   <= 1'b0;
            display_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            urg_prev_q <= urg_prev_d;
            act_q      <= act_d;
            cooler_q   <= cooler_d;
            heater_q   <= heater_d;
            display_q  <= display_d;
            busy_q     <= busy_d;
        end
    end

    assign act     = act_q;
    assign cooler  = cooler_q;
    assign heater  = heater_q;
    assign display = display_q;
    assign busy    = busy_q;

endmodule
